// File: rtl/tsc_phase_scheduler.sv
// Demand-actuated 4-way signal scheduler: round-robin green among demanding approaches, min/max green,
// yellow, all-red clearance and emergency preemption. Lamps decode registered state (no extra latency).
module tsc_phase_scheduler #(
  parameter int MIN_GREEN = 4,
  parameter int MAX_GREEN = 15,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int CNT_W     = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_tick,
  input  logic [3:0] i_det,
  input  logic       i_preempt,
  input  logic [1:0] i_preempt_dir,
  output logic [2:0] o_nl,
  output logic [2:0] o_sl,
  output logic [2:0] o_el,
  output logic [2:0] o_wl,
  output logic [1:0] o_phase,
  output logic       o_preempted
);

  localparam logic [2:0] LAMP_G = 3'b001;
  localparam logic [2:0] LAMP_Y = 3'b010;
  localparam logic [2:0] LAMP_R = 3'b100;

  typedef enum logic [1:0] {
    S_ALL_RED  = 2'd0,
    S_GREEN    = 2'd1,
    S_YELLOW   = 2'd2,
    S_PRE_HOLD = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_timer;
  logic [1:0]        r_phase;
  logic [1:0]        w_phase_nxt;
  logic [3:0]        r_pending;
  logic [3:0]        w_phase_oh;
  logic [3:0]        w_dem;
  logic [3:0]        w_clr;
  logic              w_green_on;
  logic              w_other;
  logic              w_has_next;
  logic [1:0]        w_next;
  logic [1:0]        w_idx;
  logic [2:0]        w_lamp_on;
  logic              w_min_ok;
  logic              w_max_ok;

  assign w_phase_oh = 4'b0001 << r_phase;
  assign w_green_on = (r_state == S_GREEN) || (r_state == S_PRE_HOLD);
  // A detector hit on the approach already showing green is not new demand.
  assign w_dem      = r_pending | (i_det & ~(w_green_on ? w_phase_oh : 4'b0000));
  assign w_other    = |(w_dem & ~w_phase_oh);
  assign w_min_ok   = r_timer >= CNT_W'(MIN_GREEN);
  assign w_max_ok   = r_timer >= CNT_W'(MAX_GREEN);

  always_comb begin
    w_has_next = 1'b0;
    w_next     = r_phase;
    w_idx      = r_phase;
    for (int k = 1; k < 4; k++) begin
      w_idx = r_phase + 2'(k);
      if (!w_has_next && w_dem[w_idx]) begin
        w_next     = w_idx;
        w_has_next = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    case (r_state)
      S_ALL_RED: begin
        if (r_timer >= CNT_W'(ALLRED_T)) begin
          if (i_preempt) begin
            w_state_nxt = S_PRE_HOLD;
            w_phase_nxt = i_preempt_dir;
          end else if (|w_dem) begin
            w_state_nxt = S_GREEN;
            w_phase_nxt = w_next;
          end
        end
      end
      S_GREEN: begin
        if (i_preempt && (i_preempt_dir != r_phase)) begin
          w_state_nxt = S_YELLOW;
        end else if (i_preempt) begin
          w_state_nxt = S_PRE_HOLD;
        end else if ((w_min_ok || w_max_ok) && w_other) begin
          w_state_nxt = S_YELLOW;
        end
      end
      S_YELLOW: begin
        if (r_timer >= CNT_W'(YELLOW_T)) begin
          w_state_nxt = S_ALL_RED;
        end
      end
      S_PRE_HOLD: begin
        if (!i_preempt) begin
          w_state_nxt = S_GREEN;
        end else if (i_preempt_dir != r_phase) begin
          w_state_nxt = S_YELLOW;
        end
      end
      default: w_state_nxt = S_ALL_RED;
    endcase
  end

  // Demand for an approach is consumed on the cycle it is granted green.
  assign w_clr = ((w_state_nxt == S_GREEN) && (r_state != S_GREEN)) ?
                 (4'b0001 << w_phase_nxt) : 4'b0000;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state   <= S_ALL_RED;
      r_timer   <= '0;
      r_phase   <= 2'd0;
      r_pending <= 4'b0000;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_pending <= w_dem & ~w_clr;
      if (w_state_nxt != r_state) begin
        r_timer <= '0;
      end else if (i_tick && (r_timer != {CNT_W{1'b1}})) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  always_comb begin
    w_lamp_on = LAMP_R;
    case (r_state)
      S_GREEN, S_PRE_HOLD: w_lamp_on = LAMP_G;
      S_YELLOW:            w_lamp_on = LAMP_Y;
      default:             w_lamp_on = LAMP_R;
    endcase
  end

  assign o_nl        = (r_phase == 2'd0) ? w_lamp_on : LAMP_R;
  assign o_sl        = (r_phase == 2'd1) ? w_lamp_on : LAMP_R;
  assign o_el        = (r_phase == 2'd2) ? w_lamp_on : LAMP_R;
  assign o_wl        = (r_phase == 2'd3) ? w_lamp_on : LAMP_R;
  assign o_phase     = r_phase;
  assign o_preempted = (r_state == S_PRE_HOLD);

endmodule
